// File: rtl/arcade_ram_bridge.sv
// Bridges CPU strobes in the arcade-card RAM window onto a level REQ/ACK memory port.
// Build option: define ARCADE_RAM_WBUF_EN to post CPU writes through a one-entry write buffer.
module arcade_ram_bridge (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CPU_RD_N,
    input  logic        CPU_WR_N,
    input  logic [7:0]  CPU_DI,
    input  logic        RAM_CS_N,
    input  logic [20:0] RAM_A,
    output logic [7:0]  CPU_DO,
    output logic        CPU_RDY,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [20:0] MEM_A,
    output logic [7:0]  MEM_D,
    input  logic        MEM_ACK,
    input  logic [7:0]  MEM_Q,
    output logic        BUSY
);

`ifdef ARCADE_RAM_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    state_t      state, state_n;
    logic        acc, acc_q;
    logic        start, accept, ack, posted, wb_full, issued;
    logic        stall_q, stall_n, stall_now;
    logic        cur_blk, cur_blk_n;
    logic        pend_v, pend_v_n, pend_we, pend_we_n;
    logic [20:0] pend_a, pend_a_n;
    logic [7:0]  pend_d, pend_d_n;
    logic        wb_v, wb_v_n;
    logic [20:0] wb_a, wb_a_n;
    logic [7:0]  wb_d, wb_d_n;
    logic        mem_we_n;
    logic [20:0] mem_a_n;
    logic [7:0]  mem_d_n, cpu_do_n;

    assign acc     = ~(CPU_RD_N & CPU_WR_N);
    assign start   = acc & ~acc_q & ~RAM_CS_N;
    // A stalled CPU cannot legally start another access, so such a start is dropped.
    assign accept  = start & ~stall_q;
    assign ack     = (state == S_REQ) & MEM_ACK;
    assign posted  = WBUF & ~CPU_WR_N;
    // The in-flight posted write frees its buffer entry in its own ACK cycle.
    assign wb_full = wb_v | ((state == S_REQ) & MEM_WE & ~MEM_ACK);

    assign MEM_REQ = (state == S_REQ);
    assign CPU_RDY = ~(stall_q | stall_now);
    assign BUSY    = (state != S_IDLE) | wb_v | pend_v;

    always_comb begin
        // NOTE: every next-value signal gets its hold value first so no path can infer a latch.
        state_n   = state;
        stall_n   = stall_q;
        stall_now = 1'b0;
        cur_blk_n = cur_blk;
        pend_v_n  = pend_v;
        pend_we_n = pend_we;
        pend_a_n  = pend_a;
        pend_d_n  = pend_d;
        wb_v_n    = wb_v;
        wb_a_n    = wb_a;
        wb_d_n    = wb_d;
        mem_we_n  = MEM_WE;
        mem_a_n   = MEM_A;
        mem_d_n   = MEM_D;
        cpu_do_n  = CPU_DO;
        issued    = 1'b0;

        if (ack) begin
            state_n = S_GAP;
            if (!MEM_WE) cpu_do_n = MEM_Q;
            if (cur_blk) stall_n = 1'b0;
            // A write stalled on a full buffer takes the entry in the previous write's ACK cycle.
            if (WBUF && MEM_WE && pend_v && pend_we) begin
                wb_v_n   = 1'b1;
                wb_a_n   = pend_a;
                wb_d_n   = pend_d;
                pend_v_n = 1'b0;
                stall_n  = 1'b0;
            end
        end else if (state != S_REQ) begin
            // Buffered write drains before a queued read, so reads never bypass writes.
            if (wb_v) begin
                state_n   = S_REQ;
                mem_we_n  = 1'b1;
                mem_a_n   = wb_a;
                mem_d_n   = wb_d;
                cur_blk_n = 1'b0;
                wb_v_n    = 1'b0;
                issued    = 1'b1;
            end else if (pend_v && !(WBUF && pend_we)) begin
                state_n   = S_REQ;
                mem_we_n  = pend_we;
                mem_a_n   = pend_a;
                mem_d_n   = pend_d;
                cur_blk_n = 1'b1;
                pend_v_n  = 1'b0;
                issued    = 1'b1;
            end else begin
                state_n = S_IDLE;
            end
        end

        if (accept) begin
            if (posted && !wb_full) begin
                if (state != S_REQ && !issued) begin
                    state_n   = S_REQ;
                    mem_we_n  = 1'b1;
                    mem_a_n   = RAM_A;
                    mem_d_n   = CPU_DI;
                    cur_blk_n = 1'b0;
                end else begin
                    wb_v_n = 1'b1;
                    wb_a_n = RAM_A;
                    wb_d_n = CPU_DI;
                end
            end else begin
                stall_now = 1'b1;
                stall_n   = 1'b1;
                if (state != S_REQ && !issued) begin
                    state_n   = S_REQ;
                    mem_we_n  = ~CPU_WR_N;
                    mem_a_n   = RAM_A;
                    mem_d_n   = CPU_DI;
                    cur_blk_n = 1'b1;
                end else begin
                    pend_v_n  = 1'b1;
                    pend_we_n = ~CPU_WR_N;
                    pend_a_n  = RAM_A;
                    pend_d_n  = CPU_DI;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses <= so every flop samples the same pre-edge values.
        if (!RST_N) begin
            state   <= S_IDLE;
            acc_q   <= 1'b0;
            stall_q <= 1'b0;
            cur_blk <= 1'b0;
            pend_v  <= 1'b0;
            pend_we <= 1'b0;
            pend_a  <= '0;
            pend_d  <= '0;
            wb_v    <= 1'b0;
            wb_a    <= '0;
            wb_d    <= '0;
            MEM_WE  <= 1'b0;
            MEM_A   <= '0;
            MEM_D   <= '0;
            CPU_DO  <= 8'hFF;
        end else begin
            state   <= state_n;
            acc_q   <= acc;
            stall_q <= stall_n;
            cur_blk <= cur_blk_n;
            pend_v  <= pend_v_n;
            pend_we <= pend_we_n;
            pend_a  <= pend_a_n;
            pend_d  <= pend_d_n;
            wb_v    <= wb_v_n;
            wb_a    <= wb_a_n;
            wb_d    <= wb_d_n;
            MEM_WE  <= mem_we_n;
            MEM_A   <= mem_a_n;
            MEM_D   <= mem_d_n;
            CPU_DO  <= cpu_do_n;
        end
    end

endmodule

// File: tb/tb_arcade_ram_bridge.sv
// Directed bench for arcade_ram_bridge; expectations follow the ARCADE_RAM_WBUF_EN build setting.
module tb_arcade_ram_bridge;

`ifdef ARCADE_RAM_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CPU_RD_N, CPU_WR_N, RAM_CS_N, MEM_ACK;
    logic [7:0]  CPU_DI, MEM_Q;
    logic [20:0] RAM_A;
    logic [7:0]  CPU_DO, MEM_D;
    logic        CPU_RDY, MEM_REQ, MEM_WE, BUSY;
    logic [20:0] MEM_A;

    int checks = 0;
    int fails  = 0;

    arcade_ram_bridge dut (
        .CLK(CLK), .RST_N(RST_N), .CPU_RD_N(CPU_RD_N), .CPU_WR_N(CPU_WR_N),
        .CPU_DI(CPU_DI), .RAM_CS_N(RAM_CS_N), .RAM_A(RAM_A), .CPU_DO(CPU_DO),
        .CPU_RDY(CPU_RDY), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_A(MEM_A),
        .MEM_D(MEM_D), .MEM_ACK(MEM_ACK), .MEM_Q(MEM_Q), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; CPU_RD_N = 1'b1; CPU_WR_N = 1'b1; RAM_CS_N = 1'b1;
        CPU_DI = '0; RAM_A = '0; MEM_ACK = 1'b0; MEM_Q = '0;
        tick(); tick(); look();
        checks++; if (MEM_REQ !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", MEM_REQ); end
        checks++; if (MEM_WE !== 1'b0) begin fails++; $display("FAIL rst_we: got %b want 0", MEM_WE); end
        checks++; if (MEM_A !== 21'h0) begin fails++; $display("FAIL rst_a: got %h want 0", MEM_A); end
        checks++; if (MEM_D !== 8'h00) begin fails++; $display("FAIL rst_d: got %h want 00", MEM_D); end
        checks++; if (CPU_DO !== 8'hFF) begin fails++; $display("FAIL rst_do: got %h want ff", CPU_DO); end
        checks++; if (CPU_RDY !== 1'b1) begin fails++; $display("FAIL rst_rdy: got %b want 1", CPU_RDY); end
        checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", BUSY); end
        tick(); RST_N = 1'b1; look();
    endtask

    task automatic test_read();
        int low = 0;
        tick(); RAM_CS_N = 1'b0; RAM_A = 21'h1ABCD; CPU_RD_N = 1'b0; look();
        if (CPU_RDY === 1'b0) low++;
        checks++; if (MEM_REQ !== 1'b0) begin fails++; $display("FAIL rd_req_t0: got %b want 0", MEM_REQ); end
        tick(); RAM_A = 21'h00000; look();
        if (CPU_RDY === 1'b0) low++;
        checks++; if (MEM_REQ !== 1'b1) begin fails++; $display("FAIL rd_req_t1: got %b want 1", MEM_REQ); end
        checks++; if (MEM_A !== 21'h1ABCD) begin fails++; $display("FAIL rd_addr: got %h want 1abcd", MEM_A); end
        checks++; if (MEM_WE !== 1'b0) begin fails++; $display("FAIL rd_we: got %b want 0", MEM_WE); end
        tick(); look();
        if (CPU_RDY === 1'b0) low++;
        tick(); MEM_ACK = 1'b1; MEM_Q = 8'h5A; look();
        if (CPU_RDY === 1'b0) low++;
        checks++; if (MEM_A !== 21'h1ABCD) begin fails++; $display("FAIL rd_addr_hold: got %h want 1abcd", MEM_A); end
        checks++; if (CPU_DO !== 8'hFF) begin fails++; $display("FAIL rd_do_before_ack: got %h want ff", CPU_DO); end
        tick(); MEM_ACK = 1'b0; MEM_Q = 8'h00; CPU_RD_N = 1'b1; look();
        checks++; if (CPU_RDY !== 1'b1) begin fails++; $display("FAIL rd_rdy_after: got %b want 1", CPU_RDY); end
        checks++; if (CPU_DO !== 8'h5A) begin fails++; $display("FAIL rd_do: got %h want 5a", CPU_DO); end
        checks++; if (MEM_REQ !== 1'b0) begin fails++; $display("FAIL rd_gap: got %b want 0", MEM_REQ); end
        checks++; if (low !== 4) begin fails++; $display("FAIL rd_stall_len: got %0d want 4", low); end
        tick(); look();
        checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL rd_busy_end: got %b want 0", BUSY); end
    endtask

    task automatic test_write();
        tick(); RAM_A = 21'h00010; CPU_DI = 8'h33; CPU_WR_N = 1'b0; look();
        checks++; if (CPU_RDY !== WBUF) begin fails++; $display("FAIL wr_rdy_t0: got %b want %b", CPU_RDY, WBUF); end
        tick(); RAM_A = 21'h0; CPU_DI = 8'h00; look();
        checks++; if (MEM_REQ !== 1'b1) begin fails++; $display("FAIL wr_req: got %b want 1", MEM_REQ); end
        checks++; if (MEM_WE !== 1'b1) begin fails++; $display("FAIL wr_we: got %b want 1", MEM_WE); end
        checks++; if (MEM_D !== 8'h33) begin fails++; $display("FAIL wr_d: got %h want 33", MEM_D); end
        checks++; if (MEM_A !== 21'h00010) begin fails++; $display("FAIL wr_a: got %h want 00010", MEM_A); end
        checks++; if (CPU_RDY !== WBUF) begin fails++; $display("FAIL wr_rdy_t1: got %b want %b", CPU_RDY, WBUF); end
        tick(); MEM_ACK = 1'b1; look();
        checks++; if (CPU_RDY !== WBUF) begin fails++; $display("FAIL wr_rdy_ack: got %b want %b", CPU_RDY, WBUF); end
        tick(); MEM_ACK = 1'b0; CPU_WR_N = 1'b1; look();
        checks++; if (CPU_RDY !== 1'b1) begin fails++; $display("FAIL wr_rdy_after: got %b want 1", CPU_RDY); end
        checks++; if (CPU_DO !== 8'h5A) begin fails++; $display("FAIL wr_do_kept: got %h want 5a", CPU_DO); end
        tick(); look();
        checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL wr_busy_end: got %b want 0", BUSY); end
    endtask

    // With the buffer the second write is posted during the first; without it the CPU retries after the stall.
    task automatic test_back_to_back();
        tick(); RAM_A = 21'h00100; CPU_DI = 8'h11; CPU_WR_N = 1'b0; look();
        checks++; if (CPU_RDY !== WBUF) begin fails++; $display("FAIL b2b_rdy_t0: got %b want %b", CPU_RDY, WBUF); end
        tick(); CPU_WR_N = 1'b1; look();
        checks++; if (MEM_D !== 8'h11) begin fails++; $display("FAIL b2b_d1: got %h want 11", MEM_D); end
        tick(); CPU_WR_N = WBUF ? 1'b0 : 1'b1; RAM_A = 21'h00200; CPU_DI = 8'h22; look();
        checks++; if (CPU_RDY !== 1'b0) begin fails++; $display("FAIL b2b_rdy_t2: got %b want 0", CPU_RDY); end
        checks++; if (BUSY !== 1'b1) begin fails++; $display("FAIL b2b_busy: got %b want 1", BUSY); end
        tick(); RAM_A = 21'h0; CPU_DI = 8'h00; look();
        checks++; if (CPU_RDY !== 1'b0) begin fails++; $display("FAIL b2b_rdy_t3: got %b want 0", CPU_RDY); end
        tick(); look();
        tick(); MEM_ACK = 1'b1; look();
        checks++; if (CPU_RDY !== 1'b0) begin fails++; $display("FAIL b2b_rdy_ack: got %b want 0", CPU_RDY); end
        checks++; if (MEM_D !== 8'h11) begin fails++; $display("FAIL b2b_d1_hold: got %h want 11", MEM_D); end
        checks++; if (MEM_A !== 21'h00100) begin fails++; $display("FAIL b2b_a1_hold: got %h want 00100", MEM_A); end
        tick(); MEM_ACK = 1'b0; CPU_WR_N = WBUF ? 1'b1 : 1'b0;
        if (!WBUF) begin RAM_A = 21'h00200; CPU_DI = 8'h22; end
        look();
        checks++; if (MEM_REQ !== 1'b0) begin fails++; $display("FAIL b2b_gap: got %b want 0", MEM_REQ); end
        checks++; if (CPU_RDY !== WBUF) begin fails++; $display("FAIL b2b_rdy_gap: got %b want %b", CPU_RDY, WBUF); end
        tick(); CPU_WR_N = 1'b1; RAM_A = 21'h0; CPU_DI = 8'h00; look();
        checks++; if (MEM_REQ !== 1'b1) begin fails++; $display("FAIL b2b_req2: got %b want 1", MEM_REQ); end
        checks++; if (MEM_A !== 21'h00200) begin fails++; $display("FAIL b2b_a2: got %h want 00200", MEM_A); end
        checks++; if (MEM_D !== 8'h22) begin fails++; $display("FAIL b2b_d2: got %h want 22", MEM_D); end
        checks++; if (MEM_WE !== 1'b1) begin fails++; $display("FAIL b2b_we2: got %b want 1", MEM_WE); end
        tick(); MEM_ACK = 1'b1; look();
        checks++; if (CPU_RDY !== WBUF) begin fails++; $display("FAIL b2b_rdy_ack2: got %b want %b", CPU_RDY, WBUF); end
        tick(); MEM_ACK = 1'b0; look();
        checks++; if (CPU_RDY !== 1'b1) begin fails++; $display("FAIL b2b_rdy_end: got %b want 1", CPU_RDY); end
        tick(); look();
        checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL b2b_busy_end: got %b want 0", BUSY); end
    endtask

    task automatic test_write_read();
        tick(); RAM_A = 21'h00020; CPU_DI = 8'h77; CPU_WR_N = 1'b0; look();
        checks++; if (CPU_RDY !== WBUF) begin fails++; $display("FAIL wrd_rdy_t0: got %b want %b", CPU_RDY, WBUF); end
        tick(); CPU_WR_N = 1'b1; look();
        checks++; if (MEM_WE !== 1'b1) begin fails++; $display("FAIL wrd_we1: got %b want 1", MEM_WE); end
        tick(); CPU_RD_N = WBUF ? 1'b0 : 1'b1; look();
        checks++; if (CPU_RDY !== 1'b0) begin fails++; $display("FAIL wrd_rdy_t2: got %b want 0", CPU_RDY); end
        tick(); MEM_ACK = 1'b1; look();
        checks++; if (MEM_WE !== 1'b1) begin fails++; $display("FAIL wrd_we_ack: got %b want 1", MEM_WE); end
        tick(); MEM_ACK = 1'b0; CPU_RD_N = 1'b0; look();
        checks++; if (MEM_REQ !== 1'b0) begin fails++; $display("FAIL wrd_gap: got %b want 0", MEM_REQ); end
        checks++; if (CPU_RDY !== 1'b0) begin fails++; $display("FAIL wrd_rdy_gap: got %b want 0", CPU_RDY); end
        tick(); look();
        checks++; if (MEM_REQ !== 1'b1) begin fails++; $display("FAIL wrd_req2: got %b want 1", MEM_REQ); end
        checks++; if (MEM_WE !== 1'b0) begin fails++; $display("FAIL wrd_we2: got %b want 0", MEM_WE); end
        checks++; if (MEM_A !== 21'h00020) begin fails++; $display("FAIL wrd_a2: got %h want 00020", MEM_A); end
        tick(); MEM_ACK = 1'b1; MEM_Q = 8'hC3; look();
        checks++; if (CPU_RDY !== 1'b0) begin fails++; $display("FAIL wrd_rdy_ack: got %b want 0", CPU_RDY); end
        tick(); MEM_ACK = 1'b0; MEM_Q = 8'h00; CPU_RD_N = 1'b1; look();
        checks++; if (CPU_RDY !== 1'b1) begin fails++; $display("FAIL wrd_rdy_end: got %b want 1", CPU_RDY); end
        checks++; if (CPU_DO !== 8'hC3) begin fails++; $display("FAIL wrd_do: got %h want c3", CPU_DO); end
        tick(); look();
        checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL wrd_busy_end: got %b want 0", BUSY); end
    endtask

    task automatic test_ignore();
        tick(); RAM_CS_N = 1'b1; CPU_RD_N = 1'b0; look();
        checks++; if (CPU_RDY !== 1'b1) begin fails++; $display("FAIL ign_rdy: got %b want 1", CPU_RDY); end
        tick(); CPU_RD_N = 1'b1; RAM_CS_N = 1'b0; MEM_ACK = 1'b1; MEM_Q = 8'hEE; look();
        checks++; if (MEM_REQ !== 1'b0) begin fails++; $display("FAIL ign_req: got %b want 0", MEM_REQ); end
        tick(); MEM_ACK = 1'b0; MEM_Q = 8'h00; look();
        checks++; if (MEM_REQ !== 1'b0) begin fails++; $display("FAIL ign_req2: got %b want 0", MEM_REQ); end
        checks++; if (CPU_DO !== 8'hC3) begin fails++; $display("FAIL ign_do: got %h want c3", CPU_DO); end
        checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL ign_busy: got %b want 0", BUSY); end
    endtask

    task automatic test_reset_mid();
        tick(); RAM_A = 21'h00055; CPU_RD_N = 1'b0; look();
        checks++; if (CPU_RDY !== 1'b0) begin fails++; $display("FAIL rmid_rdy_t0: got %b want 0", CPU_RDY); end
        tick(); CPU_RD_N = 1'b1; RST_N = 1'b0; look();
        checks++; if (MEM_REQ !== 1'b1) begin fails++; $display("FAIL rmid_req: got %b want 1", MEM_REQ); end
        tick(); RST_N = 1'b1; look();
        checks++; if (MEM_REQ !== 1'b0) begin fails++; $display("FAIL rmid_req_rst: got %b want 0", MEM_REQ); end
        checks++; if (CPU_RDY !== 1'b1) begin fails++; $display("FAIL rmid_rdy: got %b want 1", CPU_RDY); end
        checks++; if (CPU_DO !== 8'hFF) begin fails++; $display("FAIL rmid_do: got %h want ff", CPU_DO); end
        checks++; if (MEM_A !== 21'h0) begin fails++; $display("FAIL rmid_a: got %h want 0", MEM_A); end
        tick(); MEM_ACK = 1'b1; MEM_Q = 8'h99; look();
        tick(); MEM_ACK = 1'b0; MEM_Q = 8'h00; look();
        checks++; if (CPU_DO !== 8'hFF) begin fails++; $display("FAIL rmid_late_ack_do: got %h want ff", CPU_DO); end
        checks++; if (MEM_REQ !== 1'b0) begin fails++; $display("FAIL rmid_late_ack_req: got %b want 0", MEM_REQ); end
        checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b want 0", BUSY); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_write_read();
        test_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
